// File: rtl/rv32_alu_addsub_pipe.sv
// rtl/rv32_alu_addsub_pipe.sv - RV32 add/sub/compare ALU slice with valid/ready pipeline
// Result and flags are computed ahead of stage 0; the stages only carry them forward.
module rv32_alu_addsub_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int TAGW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_opsel,
   input  logic [XLEN-1:0] opA,
   input  logic [XLEN-1:0] opB,
   input  logic [TAGW-1:0] in_tag,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [TAGW-1:0] out_tag,
   output logic            flag_z,
   output logic            flag_c,
   output logic            flag_v,
   output logic            flag_n,
   output logic            illegal
);

   localparam int PW = XLEN + TAGW + 5;

   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("rv32_alu_addsub_pipe: STAGES must be 1..4");
   end
   if (XLEN < 8 || XLEN > 64) begin : g_bad_xlen
      $error("rv32_alu_addsub_pipe: XLEN must be 8..64");
   end

   logic            is_add, is_sub, is_slt, is_sltu;
   logic            use_inv;
   logic [XLEN-1:0] opb_eff;
   logic [XLEN:0]   sum;
   logic [XLEN-1:0] diff;
   logic            carry, ovf, lt_s, lt_u;
   logic [XLEN-1:0] res;
   logic            fz, fc, fv, fn, ill;
   logic [PW-1:0]   payload;

   always_comb begin
      is_add  = 1'b0;
      is_sub  = 1'b0;
      is_slt  = 1'b0;
      is_sltu = 1'b0;
      case (alu_opsel)
         5'd0, 5'd7, 5'd15, 5'd16, 5'd17: is_add  = 1'b1;
         5'd1, 5'd8:                      is_sub  = 1'b1;
         5'd2:                            is_slt  = 1'b1;
         5'd3:                            is_sltu = 1'b1;
         default: ;
      endcase
   end

   // Subtract and both compares share one adder fed with ~opB and a carry-in of 1.
   assign use_inv = !is_add;
   assign opb_eff = use_inv ? ~opB : opB;
   assign sum     = {1'b0, opA} + {1'b0, opb_eff} + {{XLEN{1'b0}}, use_inv};
   assign diff    = sum[XLEN-1:0];
   assign carry   = sum[XLEN];
   assign ovf     = (opA[XLEN-1] == opb_eff[XLEN-1]) && (diff[XLEN-1] != opA[XLEN-1]);
   assign lt_s    = diff[XLEN-1] ^ ovf;
   assign lt_u    = !carry;

   always_comb begin
      res = '0;
      fc  = 1'b0;
      fv  = 1'b0;
      ill = 1'b0;
      if (is_add || is_sub) begin
         res = diff;
         fc  = carry;
         fv  = ovf;
      end else if (is_slt) begin
         res = {{(XLEN-1){1'b0}}, lt_s};
         fc  = carry;
      end else if (is_sltu) begin
         res = {{(XLEN-1){1'b0}}, lt_u};
         fc  = carry;
      end else begin
         ill = 1'b1;
      end
      fz = (res == '0);
      fn = res[XLEN-1];
   end

   assign payload = {res, in_tag, fz, fc, fv, fn, ill};

   logic [STAGES-1:0] valid_q;
   logic [PW-1:0]     data_q [STAGES];
   logic              advance;

   // The whole pipe moves in lockstep; bubbles are carried, never squeezed out.
   assign advance = !valid_q[STAGES-1] || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      end else begin
         if (flush) begin
            valid_q <= '0;
         end else if (advance) begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) valid_q[i] <= valid_q[i-1];
         end
         if (advance) begin
            data_q[0] <= payload;
            for (int i = 1; i < STAGES; i++) data_q[i] <= data_q[i-1];
         end
      end
   end

   assign in_ready  = advance;
   assign out_valid = valid_q[STAGES-1];
   assign {result, out_tag, flag_z, flag_c, flag_v, flag_n, illegal} = data_q[STAGES-1];

endmodule

// File: tb/tb_rv32_alu_addsub_pipe.sv
// tb/tb_rv32_alu_addsub_pipe.sv - scoreboard bench for rv32_alu_addsub_pipe
module tb_rv32_alu_addsub_pipe;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  tag;
      logic        z, c, v, n, ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  alu_opsel = '0;
   logic [31:0] opA = '0;
   logic [31:0] opB = '0;
   logic [4:0]  in_tag = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic [4:0]  out_tag;
   logic        flag_z, flag_c, flag_v, flag_n, illegal;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   rv32_alu_addsub_pipe #(.XLEN(32), .STAGES(2), .TAGW(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_opsel(alu_opsel), .opA(opA), .opB(opB), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
      .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", nm, act, exp);
      end
   endtask

   // Monitor: compare the head on every valid output, pop only on an actual transfer.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            if (out_ready) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual tag %0d required none", out_tag);
            end
         end else begin
            chk($sformatf("result_tag%0d", sb[0].tag),
                {22'd0, result, out_tag, flag_z, flag_c, flag_v, flag_n, illegal},
                {22'd0, sb[0]});
            if (out_ready) void'(sb.pop_front());
         end
      end
   end

   // Called at posedge+1; in_valid stays up until the edge that accepts it.
   task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input exp_t e, input bit push);
      int waited = 0;
      alu_opsel = op; opA = a; opB = b; in_tag = tag; in_valid = 1'b1;
      #1;
      while (!in_ready && waited < 50) begin
         @(posedge clk); #2;
         waited++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      else if (push) sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   function automatic exp_t mk(logic [31:0] r, logic [4:0] t, logic z, logic c, logic v,
                               logic n, logic i);
      exp_t e;
      e.res = r; e.tag = t; e.z = z; e.c = c; e.v = v; e.n = n; e.ill = i;
      return e;
   endfunction

   initial begin
      #3;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_outputs", {result, out_tag, flag_z, flag_c, flag_v, flag_n, illegal}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: accept at edge N, out_valid after edge N+1.
      send(5'd0, 32'hFFFF_FFFF, 32'h1, 5'd3, mk(32'h0, 5'd3, 1, 1, 0, 0, 0), 1);
      chk("latency_early", out_valid, 0);
      @(posedge clk); #1;
      chk("latency_on_time", out_valid, 1);
      @(posedge clk); #1;

      send(5'd8,  32'h8000_0000, 32'h1,         5'd4,  mk(32'h7FFF_FFFF, 5'd4, 0, 1, 1, 0, 0), 1);
      send(5'd1,  32'h0,         32'h1,         5'd5,  mk(32'hFFFF_FFFF, 5'd5, 0, 0, 0, 1, 0), 1);
      send(5'd2,  32'hFFFF_FFFF, 32'h1,         5'd6,  mk(32'h1,         5'd6, 0, 1, 0, 0, 0), 1);
      send(5'd3,  32'hFFFF_FFFF, 32'h1,         5'd7,  mk(32'h0,         5'd7, 1, 1, 0, 0, 0), 1);
      send(5'd5,  32'h1234,      32'h1,         5'd8,  mk(32'h0,         5'd8, 1, 0, 0, 0, 1), 1);
      send(5'd17, 32'h7FFF_FFFF, 32'h1,         5'd9,  mk(32'h8000_0000, 5'd9, 0, 0, 1, 1, 0), 1);
      send(5'd16, 32'h5,         32'h3,         5'd10, mk(32'h8,         5'd10, 0, 0, 0, 0, 0), 1);
      send(5'd1,  32'h5,         32'h5,         5'd11, mk(32'h0,         5'd11, 1, 1, 0, 0, 0), 1);
      send(5'd7,  32'h1,         32'h2,         5'd12, mk(32'h3,         5'd12, 0, 0, 0, 0, 0), 1);
      send(5'd15, 32'h8000_0000, 32'h8000_0000, 5'd13, mk(32'h0,         5'd13, 1, 1, 1, 0, 0), 1);
      send(5'd31, 32'hDEAD_BEEF, 32'h1,         5'd14, mk(32'h0,         5'd14, 1, 0, 0, 0, 1), 1);
      send(5'd3,  32'h1,         32'hFFFF_FFFF, 5'd15, mk(32'h1,         5'd15, 0, 0, 0, 0, 0), 1);
      send(5'd2,  32'h1,         32'h1,         5'd16, mk(32'h0,         5'd16, 1, 1, 0, 0, 0), 1);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: two accepts, stall holding tag 1, then gapless drain.
      out_ready = 1'b0;
      fork
         begin
            for (int t = 1; t <= 4; t++)
               send(5'd0, t, 32'h10, t[4:0], mk(t + 32'h10, t[4:0], 0, 0, 0, 0, 0), 1);
         end
         begin
            repeat (5) @(posedge clk);
            #2;
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_hold_tag", out_tag, 1);
            @(posedge clk); #1;
            out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk($sformatf("bp_no_gap%0d", k), out_valid, 1);
            end
         end
      join
      repeat (3) @(posedge clk);
      #1;

      // Flush with two ops in flight plus a simultaneous offer.
      out_ready = 1'b0;
      send(5'd0, 32'h1, 32'h1, 5'd20, mk(32'h0, 5'd0, 0, 0, 0, 0, 0), 0);
      send(5'd0, 32'h2, 32'h1, 5'd21, mk(32'h0, 5'd0, 0, 0, 0, 0, 0), 0);
      alu_opsel = 5'd0; opA = 32'h3; opB = 32'h1; in_tag = 5'd22; in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", out_valid, 0);
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("flush_quiet", out_valid, 0);

      // Asynchronous reset mid-cycle with ops in flight.
      out_ready = 1'b0;
      send(5'd0, 32'h7, 32'h1, 5'd23, mk(32'h0, 5'd0, 0, 0, 0, 0, 0), 0);
      send(5'd0, 32'h8, 32'h1, 5'd24, mk(32'h0, 5'd0, 0, 0, 0, 0, 0), 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_outputs", {result, out_tag, flag_z, flag_c, flag_v, flag_n, illegal}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(5'd8, 32'h10, 32'h3, 5'd25, mk(32'hD, 5'd25, 0, 1, 0, 0, 0), 1);
      chk("post_reset_stage0_only", out_valid, 0);
      @(posedge clk); #1;
      chk("post_reset_first_result", out_valid, 1);

      for (int w = 0; w < 200 && sb.size() != 0; w++) @(posedge clk);
      chk("drain_empty", sb.size(), 0);
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32_alu_addsub_pipe.md
RV32_ALU_ADDSUB_PIPE -- requirements
Module: rv32_alu_addsub_pipe

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal range 8..64.
REQ-002 Parameter STAGES, default 2: pipeline register count, legal 1..4; elaboration SHALL fail outside this range.
REQ-003 Parameter TAGW, default 5: width of the sideband tag passed through unchanged (typically rd index).
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  block can accept this cycle.
REQ-008 alu_opsel  input  5  operation code.
REQ-009 opA, opB  input  XLEN each  operands.
REQ-010 in_tag  input  TAGW  sideband tag.
REQ-011 flush  input  1  synchronous kill of all in-flight operations.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 result  output  XLEN  computed value.
REQ-015 out_tag  output  TAGW  tag of the result.
REQ-016 flag_z, flag_c, flag_v, flag_n  output  1 each  zero, carry, signed overflow, negative.
REQ-017 illegal  output  1  the result came from an unsupported alu_opsel.

Function
REQ-018 Decode: ADD for alu_opsel in {0,7,15,16,17}; SUB for {1,8}; SLT for 2; SLTU for 3; every other code is illegal.
REQ-019 ADD: result = (opA + opB) mod 2^XLEN; flag_c = carry out of bit XLEN-1.
REQ-020 SUB, SLT and SLTU: the internal difference is opA + ~opB + 1; flag_c = carry out (1 = no borrow).
REQ-021 flag_v: signed overflow of the ADD/SUB operation; it is 0 for SLT, SLTU and illegal codes.
REQ-022 SLT: result = 1 if signed opA < signed opB, else 0; SLTU uses the unsigned compare; the upper XLEN-1 bits are zero.
REQ-023 Illegal code: result = 0, flag_z = 1, flags c/v/n = 0, illegal = 1.
REQ-024 For legal codes: flag_z = (result == 0), flag_n = result[XLEN-1], illegal = 0.
REQ-025 All computation completes combinationally ahead of stage 0; later stages only carry the values forward.
REQ-026 Handshake: advance = !valid[STAGES-1] || out_ready; in_ready = advance; the whole pipeline moves only when advance = 1.
REQ-027 Accept occurs when in_valid && in_ready; the accepted operation enters stage 0 with valid set.
REQ-028 Latency: with out_ready held high, an operation accepted at edge N SHALL present out_valid = 1 during the cycle after edge N+STAGES-1, i.e. exactly STAGES cycles.
REQ-029 Bubbles are not collapsed; throughput is one operation per cycle while out_ready = 1.
REQ-030 While out_valid && !out_ready, result, out_tag, flags and illegal SHALL hold stable.
REQ-031 Results SHALL emerge in acceptance order with the matching tag; there is no loss or duplication.
REQ-032 Flush: at the edge where flush = 1, every stage valid SHALL clear; a simultaneous in_valid is dropped.
REQ-033 Flush has priority over accept and over out_ready.
REQ-034 out_valid SHALL be 0 in the cycle following a flush edge.
REQ-035 in_ready does not depend on in_valid; this leaves no combinational loop from in_valid to in_ready.

Reset
REQ-036 When rst_n = 0, all stage valids, data, tags and flags SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-037 Outputs during reset: out_valid = 0, result = 0, out_tag = 0, all flags = 0, illegal = 0; in_ready = 1.
REQ-038 An assertion of reset while operations are in flight discards them; no result from before reset appears after it.
REQ-039 The first accept is possible at the first rising edge after rst_n deasserts.

Verification (XLEN=32, STAGES=2, out_ready=1 unless stated)
REQ-040 ADD: opsel 0, opA 0xFFFFFFFF, opB 0x1, tag 3 -> two cycles later out_valid = 1, result 0x0, z = 1, c = 1, v = 0, n = 0, out_tag 3.
REQ-041 SUB: opsel 8, opA 0x80000000, opB 0x1 -> result 0x7FFFFFFF, v = 1, c = 1, n = 0; then opA 0x0, opB 0x1 -> 0xFFFFFFFF, c = 0, n = 1.
REQ-042 Compare: opA 0xFFFFFFFF, opB 0x1; opsel 2 -> result 1; opsel 3 -> result 0; v = 0 in both cases.
REQ-043 Backpressure: out_ready = 0, four back-to-back offers with tags 1..4 -> in_ready drops after two accepts and the output holds tag 1; release out_ready -> tags 1, 2, 3, 4 in order, with no gaps once flowing.
REQ-044 Flush and reset: flush with two operations in flight -> out_valid = 0 the next cycle and never shows those tags; rst_n pulse mid-stream -> outputs zero asynchronously and in_ready = 1.
REQ-045 Illegal: opsel 5, opA 0x1234, opB 0x1 -> result 0, illegal = 1, z = 1, c = v = n = 0.
